// File: rtl/moving_avg_filter.sv
// Streaming moving-average filter over the last M unsigned samples, with a running sum and a shifted mean.
// Optional build macro MAVG_ROUND_EN: when defined, the mean is rounded half-up instead of truncated.
module moving_avg_filter #(
  parameter  int unsigned DATA_W = 12,
  parameter  int unsigned M      = 8,
  localparam int unsigned LOG2_M = $clog2(M),
  localparam int unsigned SUM_W  = DATA_W + LOG2_M
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] y,
  output logic              y_valid,
  output logic              filled,
  output logic [SUM_W-1:0]  sum
);

  localparam int unsigned CNT_W = LOG2_M + 1;

  // A shift-based mean only works for a power-of-two window.
  generate
    if ((M < 2) || ((M & (M - 1)) != 0)) begin : g_bad_m
      $error("moving_avg_filter: M must be a power of two and at least 2");
    end
  endgenerate

  typedef enum logic {ST_FILL, ST_RUN} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   tap_q [M];
  logic [DATA_W-1:0]   tap_d [M];
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   y_q, y_d;
  logic                y_valid_q, y_valid_d;
  logic                filled_q, filled_d;
  logic                accept_c;
  logic [SUM_W-1:0]    sum_nxt_c;
  logic [DATA_W-1:0]   mean_c;

  assign accept_c  = en && in_valid && !clr;
  // The dropped tap is zero while filling, so the subtraction never wraps.
  assign sum_nxt_c = sum_q + SUM_W'(x) - SUM_W'(tap_q[M-1]);

`ifdef MAVG_ROUND_EN
  assign mean_c = DATA_W'((sum_nxt_c + SUM_W'(M / 2)) >> LOG2_M);
`else
  assign mean_c = DATA_W'(sum_nxt_c >> LOG2_M);
`endif

  // Next-state, tap shift and output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tap_d     = tap_q;
    sum_d     = sum_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    filled_d  = filled_q;
    if (clr) begin
      state_d  = ST_FILL;
      cnt_d    = '0;
      sum_d    = '0;
      y_d      = '0;
      filled_d = 1'b0;
      for (int unsigned i = 0; i < M; i++) tap_d[i] = '0;
    end else if (accept_c) begin
      tap_d[0] = x;
      for (int unsigned i = 1; i < M; i++) tap_d[i] = tap_q[i-1];
      sum_d = sum_nxt_c;
      if (state_q == ST_FILL) begin
        if (cnt_q == CNT_W'(M - 1)) begin
          state_d   = ST_RUN;
          cnt_d     = CNT_W'(M);
          filled_d  = 1'b1;
          y_valid_d = 1'b1;
          y_d       = mean_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        y_valid_d = 1'b1;
        y_d       = mean_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      sum_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      filled_q  <= 1'b0;
      for (int unsigned i = 0; i < M; i++) tap_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      filled_q  <= filled_d;
      tap_q     <= tap_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign filled  = filled_q;
  assign sum     = sum_q;

endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed plus random bench for moving_avg_filter (M=8, DATA_W=12) with a reference window model and scoreboard.
module tb_moving_avg_filter;

  localparam int DW = 12;
  localparam int SW = 15;
`ifdef MAVG_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          clr;
  logic          in_valid;
  logic [DW-1:0] x;
  logic [DW-1:0] y;
  logic          y_valid;
  logic          filled;
  logic [SW-1:0] sum;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        v;
    logic        f;
    logic [31:0] y;
    logic [31:0] s;
  } exp_t;

  exp_t        sb[$];
  int unsigned win[$];
  int unsigned msum;
  int unsigned my;
  int unsigned saved_sum;

  moving_avg_filter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .in_valid (in_valid),
    .x        (x),
    .y        (y),
    .y_valid  (y_valid),
    .filled   (filled),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int unsigned mean_of(input int unsigned s);
    return (s + (RND != 0 ? 32'd4 : 32'd0)) >> 3;
  endfunction

  task automatic model_reset();
    win.delete();
    msum = 0;
    my   = 0;
    sb.delete();
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare after the edge.
  task automatic step(input logic e, input logic c, input logic v, input logic [DW-1:0] xx);
    exp_t ex;
    en = e; clr = c; in_valid = v; x = xx;
    ex.v = 1'b0;
    if (c) begin
      win.delete();
      msum = 0;
      my   = 0;
    end else if (e && v) begin
      win.push_front(int'(xx));
      msum += int'(xx);
      if (win.size() > 8) msum -= win.pop_back();
      if (win.size() == 8) begin
        my   = mean_of(msum);
        ex.v = 1'b1;
      end
    end
    ex.f = (win.size() == 8);
    ex.y = my;
    ex.s = msum;
    sb.push_back(ex);
    @(posedge clk);
    #1;
    ex = sb.pop_front();
    chk("y_valid", 32'(y_valid), 32'(ex.v));
    chk("filled",  32'(filled),  32'(ex.f));
    chk("sum",     32'(sum),     ex.s);
    chk("y",       32'(y),       ex.y);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; x = '0;
    model_reset();

    // Reset held with random inputs: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; in_valid = 1'($urandom); x = DW'($urandom); clr = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_y",       32'(y),       0);
      chk("rst_y_valid", 32'(y_valid), 0);
      chk("rst_filled",  32'(filled),  0);
      chk("rst_sum",     32'(sum),     0);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Constant fill.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, DW'(100));
    chk("const_y",      32'(y),       100);
    chk("const_sum",    32'(sum),     800);
    chk("const_filled", 32'(filled),  1);
    step(1'b1, 1'b0, 1'b1, DW'(100));
    chk("const_y9",     32'(y),       100);

    // Ramp from an empty window.
    step(1'b1, 1'b1, 1'b0, DW'(0));
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, DW'(i));
    chk("ramp_sum", 32'(sum), 28);
    chk("ramp_y",   32'(y),   RND != 0 ? 4 : 3);
    step(1'b1, 1'b0, 1'b1, DW'(8));
    chk("ramp_sum9", 32'(sum), 36);
    chk("ramp_y9",   32'(y),   RND != 0 ? 5 : 4);

    // Full scale up, then drain to zero.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, DW'(4095));
    chk("fs_sum", 32'(sum), 32760);
    chk("fs_y",   32'(y),   4095);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, DW'(0));
    chk("fs_drain_y",   32'(y),   0);
    chk("fs_drain_sum", 32'(sum), 0);

    // clr collides with a valid sample mid-RUN.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, DW'($urandom));
    step(1'b1, 1'b1, 1'b1, DW'(500));
    chk("clr_sum",    32'(sum),     0);
    chk("clr_filled", 32'(filled),  0);
    chk("clr_valid",  32'(y_valid), 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b1, DW'(i * 37 + 11));
    chk("clr_refill_nv", 32'(y_valid), 0);
    step(1'b1, 1'b0, 1'b1, DW'(900));
    chk("clr_refill_v",  32'(y_valid), 1);

    // en gating while in_valid stays high.
    saved_sum = msum;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, DW'($urandom));
    chk("en_frozen_sum", 32'(sum), saved_sum);
    step(1'b1, 1'b0, 1'b1, DW'(1234));

    // clr acts even with en low.
    step(1'b0, 1'b1, 1'b1, DW'(77));
    chk("clr_en_low_sum", 32'(sum), 0);

    // Random traffic.
    for (int i = 0; i < 60; i++)
      step(1'($urandom % 8 != 0), 1'($urandom % 20 == 0), 1'($urandom % 4 != 0), DW'($urandom));

    // Reset asserted mid-stream clears the in-flight strobe immediately.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, DW'(300 + i));
    chk("pre_arst_valid", 32'(y_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  32'(y_valid), 0);
    chk("arst_sum",    32'(sum),     0);
    chk("arst_filled", 32'(filled),  0);
    chk("arst_y",      32'(y),       0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, DW'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
